// File: rtl/multi_channel_pattern_detector.sv
// Multi-channel serial pattern detector with a runtime-programmable pattern.
// Each channel has its own history, fill count, match pulse and saturating counter.
module multi_channel_pattern_detector #(
    parameter int                 NCH         = 2,
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 4,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = {MAX_LEN{1'b0}},
    parameter int                 DEF_LEN     = MAX_LEN,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_load,
    input  logic [MAX_LEN-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_overlap,
    input  logic                 cnt_clr,
    input  logic [NCH-1:0]       w_valid,
    input  logic [NCH-1:0]       w,
    output logic [NCH-1:0]       z,
    output logic [NCH*CNT_W-1:0] match_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_V =
        (DEF_LEN < 1 || DEF_LEN > MAX_LEN) ? MAX_LEN_V : LEN_W'(DEF_LEN);

    logic [MAX_LEN-1:0] act_pat;
    logic [LEN_W-1:0]   act_len;
    logic               act_ovl;
    logic [LEN_W-1:0]   load_len;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] pat_m;

    always_comb begin
        load_len = cfg_len;
        if (cfg_len == '0 || cfg_len > MAX_LEN_V)
            load_len = MAX_LEN_V;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_pat <= DEF_PATTERN;
            act_len <= DEF_LEN_V;
            act_ovl <= 1'b1;
        end else if (cfg_load) begin
            act_pat <= cfg_pattern;
            act_len <= load_len;
            act_ovl <= cfg_overlap;
        end
    end

    // Low act_len bits are significant; a shift by MAX_LEN yields all ones.
    assign len_mask = ~({MAX_LEN{1'b1}} << act_len);
    assign pat_m    = act_pat & len_mask;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [MAX_LEN-1:0] hist;
        logic [MAX_LEN-1:0] hist_nx;
        logic [LEN_W-1:0]   fill;
        logic [LEN_W-1:0]   fill_nx;
        logic               hit;
        logic               zq;
        logic [CNT_W-1:0]   cnt;

        always_comb begin
            hist_nx = {hist[MAX_LEN-2:0], w[i]};
            fill_nx = (fill == act_len) ? act_len : fill + LEN_W'(1);
            hit     = w_valid[i] && !cfg_load && (fill_nx == act_len)
                      && ((hist_nx & len_mask) == pat_m);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hist <= '0;
                fill <= '0;
                zq   <= 1'b0;
                cnt  <= '0;
            end else begin
                zq <= hit;
                if (cfg_load) begin
                    hist <= '0;
                    fill <= '0;
                end else if (w_valid[i]) begin
                    hist <= hist_nx;
                    fill <= (hit && !act_ovl) ? '0 : fill_nx;
                end
                if (cnt_clr)
                    cnt <= '0;
                else if (hit && cnt != {CNT_W{1'b1}})
                    cnt <= cnt + CNT_W'(1);
            end
        end

        assign z[i]                       = zq;
        assign match_cnt[i*CNT_W +: CNT_W] = cnt;
    end

endmodule

// File: tb/tb_multi_channel_pattern_detector.sv
// Self-checking bench for multi_channel_pattern_detector (NCH=2, MAX_LEN=8, CNT_W=4).
// Expected z values are queued as stimulus is driven and checked after each edge.
module tb_multi_channel_pattern_detector;

    localparam int NCH     = 2;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cfg_load = 1'b0;
    logic [MAX_LEN-1:0]   cfg_pattern = '0;
    logic [LEN_W-1:0]     cfg_len = '0;
    logic                 cfg_overlap = 1'b0;
    logic                 cnt_clr = 1'b0;
    logic [NCH-1:0]       w_valid = '0;
    logic [NCH-1:0]       w = '0;
    logic [NCH-1:0]       z;
    logic [NCH*CNT_W-1:0] match_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NCH-1:0] exp_q[$];
    string          name_q[$];

    multi_channel_pattern_detector #(
        .NCH(NCH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .w_valid(w_valid), .w(w), .z(z), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop the expectation queued for this edge, compare after it.
    always @(posedge clk) begin
        logic [NCH-1:0] e;
        string          nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            #2;
            n_tests++;
            if (z !== e) begin
                n_fail++;
                $display("FAIL %s: z=%b expected %b at %0t", nm, z, e, $time);
            end
        end
    end

    task automatic drv(input logic [NCH-1:0] v, input logic [NCH-1:0] d,
                       input logic [NCH-1:0] ez, input string nm);
        w_valid = v;
        w       = d;
        exp_q.push_back(ez);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        w_valid  = '0;
        w        = '0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        drv(2'b11, 2'b11, 2'b00, "load");
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        drv(2'b00, 2'b00, 2'b00, "clr");
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (z !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_z: z=%b expected 00", z);
        end
        n_tests++;
        if (match_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_cnt: cnt=%h expected 00", match_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_defaults(input string tag);
        for (int k = 0; k < 7; k++) drv(2'b01, 2'b00, 2'b00, tag);
        drv(2'b01, 2'b00, 2'b01, tag);
        drv(2'b01, 2'b00, 2'b01, tag);
        n_tests++;
        if (match_cnt[3:0] !== 4'd2) begin
            n_fail++;
            $display("FAIL %s_cnt0: cnt0=%0d expected 2", tag, match_cnt[3:0]);
        end
        clr();
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] e;
        s = 7'b1011011;
        e = 7'b0001001;
        load(8'b1011, 4'd4, 1'b1);
        for (int k = 6; k >= 0; k--)
            drv(2'b01, {1'b0, s[k]}, {1'b0, e[k]}, "t1_ovl");
        n_tests++;
        if (match_cnt[3:0] !== 4'd2) begin
            n_fail++;
            $display("FAIL t1_cnt0: cnt0=%0d expected 2", match_cnt[3:0]);
        end
        n_tests++;
        if (match_cnt[7:4] !== 4'd0) begin
            n_fail++;
            $display("FAIL t1_cnt1: cnt1=%0d expected 0", match_cnt[7:4]);
        end
    endtask

    task automatic test_no_overlap();
        logic [6:0] s;
        logic [6:0] e;
        s = 7'b1011011;
        e = 7'b0001000;
        clr();
        load(8'b1011, 4'd4, 1'b0);
        for (int k = 6; k >= 0; k--)
            drv(2'b01, {1'b0, s[k]}, {1'b0, e[k]}, "t2_novl");
        n_tests++;
        if (match_cnt[3:0] !== 4'd1) begin
            n_fail++;
            $display("FAIL t2_cnt0: cnt0=%0d expected 1", match_cnt[3:0]);
        end
    endtask

    task automatic test_valid_gaps();
        logic [3:0] s;
        s = 4'b1011;
        load(8'b1011, 4'd4, 1'b1);
        for (int k = 3; k >= 0; k--) begin
            drv(2'b10, {s[k], 1'b1}, (k == 0) ? 2'b10 : 2'b00, "t3_valid");
            drv(2'b00, 2'($urandom_range(0, 3)), 2'b00, "t3_gap");
        end
        n_tests++;
        if (match_cnt[7:4] !== 4'd1) begin
            n_fail++;
            $display("FAIL t3_cnt1: cnt1=%0d expected 1", match_cnt[7:4]);
        end
    endtask

    task automatic test_saturate();
        load(8'b1, 4'd1, 1'b1);
        for (int k = 0; k < 20; k++) drv(2'b01, 2'b01, 2'b01, "t4_len1");
        n_tests++;
        if (match_cnt[3:0] !== 4'd15) begin
            n_fail++;
            $display("FAIL t4_sat: cnt0=%0d expected 15", match_cnt[3:0]);
        end
        drv(2'b01, 2'b00, 2'b00, "t4_zero");
        cnt_clr = 1'b1;
        drv(2'b01, 2'b01, 2'b01, "t4_clr_pulse");
        n_tests++;
        if (match_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL t4_clr: cnt=%h expected 00", match_cnt);
        end
    endtask

    task automatic test_cfg_flush();
        load(8'b1011, 4'd4, 1'b1);
        drv(2'b01, 2'b01, 2'b00, "t5_pre");
        drv(2'b01, 2'b00, 2'b00, "t5_pre");
        drv(2'b01, 2'b01, 2'b00, "t5_pre");
        cfg_load = 1'b1;
        drv(2'b01, 2'b01, 2'b00, "t5_load");
        drv(2'b01, 2'b01, 2'b00, "t5_post");
        drv(2'b01, 2'b01, 2'b00, "t5_post");
        drv(2'b01, 2'b00, 2'b00, "t5_post");
        drv(2'b01, 2'b01, 2'b00, "t5_post");
        drv(2'b01, 2'b01, 2'b01, "t5_match");
        n_tests++;
        if (match_cnt[3:0] !== 4'd1) begin
            n_fail++;
            $display("FAIL t5_cnt0: cnt0=%0d expected 1", match_cnt[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] s;
        s = 4'b1011;
        clr();
        for (int k = 3; k >= 0; k--)
            drv(2'b11, {s[k], s[k]}, (k == 0) ? 2'b11 : 2'b00, "bb_both");
        n_tests++;
        if (match_cnt !== 8'h11) begin
            n_fail++;
            $display("FAIL bb_cnt: cnt=%h expected 11", match_cnt);
        end
    endtask

    task automatic test_async_reset();
        load(8'b1, 4'd1, 1'b1);
        drv(2'b01, 2'b01, 2'b01, "t6_pulse");
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (z !== 2'b00) begin
            n_fail++;
            $display("FAIL t6_z: z=%b expected 00", z);
        end
        n_tests++;
        if (match_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL t6_cnt: cnt=%h expected 00", match_cnt);
        end
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_defaults("t6_def");
    endtask

    initial begin
        test_reset();
        test_defaults("def");
        test_overlap();
        test_no_overlap();
        test_valid_gaps();
        test_saturate();
        test_cfg_flush();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
